// File: rtl/intdiv_pkg.sv
// rtl/intdiv_pkg.sv - shared types and funct3 encodings for the iterative divider
package intdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divstate_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

endpackage

// File: rtl/intdiv_if.sv
// rtl/intdiv_if.sv - Execute-stage request/result bundle between pipeline and divider
interface intdiv_if #(
  parameter int XLEN = 64
);
  logic            FlushE;
  logic            MDUE;
  logic [2:0]      Funct3E;
  logic            W64E;
  logic [XLEN-1:0] ForwardedSrcAE;
  logic [XLEN-1:0] ForwardedSrcBE;
  logic            DivBusyE;
  logic            DivDoneE;
  logic [XLEN-1:0] DivResultE;

  modport master (
    output FlushE, MDUE, Funct3E, W64E, ForwardedSrcAE, ForwardedSrcBE,
    input  DivBusyE, DivDoneE, DivResultE
  );

  modport slave (
    input  FlushE, MDUE, Funct3E, W64E, ForwardedSrcAE, ForwardedSrcBE,
    output DivBusyE, DivDoneE, DivResultE
  );
endinterface

// File: rtl/intdiv_step.sv
// rtl/intdiv_step.sv - one combinational restoring-division step
module intdiv_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] dvs_i,
  input  logic            bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);
  logic [XLEN:0] shifted;

  // The stored remainder is always below the divisor, so the difference fits in XLEN bits.
  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= {1'b0, dvs_i});
    rem_o   = q_o ? (shifted[XLEN-1:0] - dvs_i) : shifted[XLEN-1:0];
  end
endmodule

// File: rtl/intdiv_iter.sv
// rtl/intdiv_iter.sv - radix-2 iterative DIV/DIVU/REM/REMU (+W forms), one quotient bit per cycle
module intdiv_iter
  import intdiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic   clk,
  input  logic   reset,
  intdiv_if.slave dif
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  divstate_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             remop_q, remop_d;
  logic             w_q, w_d;

  logic            signed_op, rem_op, w, start;
  logic            sa, sb, div0, ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, special_res;
  logic [XLEN-1:0] step_rem, q_fin, q_cor, r_cor;
  logic            step_q;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    logic [XLEN-1:0] r;
    r       = {XLEN{x[31]}};
    r[31:0] = x;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = x;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] fit(input logic w_i, input logic [XLEN-1:0] x);
    return w_i ? sext32(x[31:0]) : x;
  endfunction

  always_comb begin
    signed_op = (dif.Funct3E == F3_DIV) | (dif.Funct3E == F3_REM);
    rem_op    = (dif.Funct3E == F3_REM) | (dif.Funct3E == F3_REMU);
    w         = dif.W64E & (XLEN == 64);
    start     = dif.MDUE & dif.Funct3E[2] & ~dif.FlushE & (state_q == IDLE);

    a_ext = w ? (signed_op ? sext32(dif.ForwardedSrcAE[31:0]) : zext32(dif.ForwardedSrcAE[31:0]))
              : dif.ForwardedSrcAE;
    b_ext = w ? (signed_op ? sext32(dif.ForwardedSrcBE[31:0]) : zext32(dif.ForwardedSrcBE[31:0]))
              : dif.ForwardedSrcBE;
    sa    = signed_op & a_ext[XLEN-1];
    sb    = signed_op & b_ext[XLEN-1];
    a_mag = sa ? -a_ext : a_ext;
    b_mag = sb ? -b_ext : b_ext;

    div0 = (b_ext == '0);
    ovf  = signed_op & (b_ext == '1) &
           (w ? (a_ext[31:0] == 32'h8000_0000) : (a_ext == MOST_NEG));
    if (div0)
      special_res = fit(w, rem_op ? a_ext : '1);
    else
      special_res = fit(w, rem_op ? '0 : a_ext);

    q_fin = {quo_q[XLEN-2:0], step_q};
    q_cor = negq_q ? -q_fin : q_fin;
    r_cor = negr_q ? -step_rem : step_rem;
  end

  intdiv_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .bit_i (quo_q[XLEN-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    remop_d  = remop_q;
    w_d      = w_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (div0 | ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            // W dividends are pre-aligned so the MSB to consume is always bit XLEN-1.
            quo_d   = w ? (a_mag << (XLEN - 32)) : a_mag;
            dvs_d   = b_mag;
            rem_d   = '0;
            negq_d  = sa ^ sb;
            negr_d  = sa;
            remop_d = rem_op;
            w_d     = w;
            cnt_d   = w ? CNT_W'(31) : CNT_W'(XLEN - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (dif.FlushE) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = q_fin;
          if (cnt_q == '0) begin
            result_d = fit(w_q, remop_q ? r_cor : q_cor);
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      remop_q  <= 1'b0;
      w_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      remop_q  <= remop_d;
      w_q      <= w_d;
    end
  end

  assign dif.DivBusyE   = start | (state_q == BUSY);
  assign dif.DivDoneE   = (state_q == DONE);
  assign dif.DivResultE = result_q;
endmodule

// File: tb/tb_intdiv_iter.sv
// tb/tb_intdiv_iter.sv - directed self-checking bench for intdiv_iter (XLEN=64)
module tb_intdiv_iter;
  import intdiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  intdiv_if #(.XLEN(64)) dif ();

  intdiv_iter #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_div(input string tag, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input int exp_lat);
    int   lat;
    int   busy_n;
    logic seen;
    dif.Funct3E        = f3;
    dif.W64E           = w;
    dif.ForwardedSrcAE = a;
    dif.ForwardedSrcBE = b;
    dif.MDUE           = 1'b1;
    #1;
    busy_n = dif.DivBusyE ? 1 : 0;
    @(posedge clk); #1;
    dif.MDUE = 1'b0;
    lat = 1;
    while (!dif.DivDoneE && lat < 200) begin
      if (dif.DivBusyE) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    seen = dif.DivDoneE;
    check($sformatf("%s_done", tag), 64'(seen), 64'd1);
    check($sformatf("%s_lat", tag), 64'(lat), 64'(exp_lat));
    check($sformatf("%s_busycyc", tag), 64'(busy_n), 64'(exp_lat));
    check($sformatf("%s_res", tag), dif.DivResultE, exp_res);
    check($sformatf("%s_busy_at_done", tag), 64'(dif.DivBusyE), 64'd0);
    @(posedge clk); #1;
    check($sformatf("%s_pulse", tag), 64'(dif.DivDoneE), 64'd0);
  endtask

  initial begin
    reset              = 1'b0;
    dif.FlushE         = 1'b0;
    dif.MDUE           = 1'b0;
    dif.Funct3E        = 3'b000;
    dif.W64E           = 1'b0;
    dif.ForwardedSrcAE = '0;
    dif.ForwardedSrcBE = '0;
    #2;
    check("rst_busy", 64'(dif.DivBusyE), 64'd0);
    check("rst_done", 64'(dif.DivDoneE), 64'd0);
    check("rst_res", dif.DivResultE, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    run_div("divu_100_7", F3_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run_div("remu_100_7", F3_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    run_div("div_m7_2", F3_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_div("rem_m7_2", F3_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_div("rem_7_m2", F3_REM, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
    run_div("div_m100_m7", F3_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
            64'd14, 65);
    run_div("divu_big", F3_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
            64'h0FFF_FFFF_FFFF_FFFF, 65);
    run_div("divu_5_0", F3_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_div("remu_5_0", F3_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    run_div("div_ovf", F3_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 1);
    run_div("rem_ovf", F3_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'd0, 1);
    run_div("divw_m8_3", F3_DIV, 1'b1, 64'h1234_5678_FFFF_FFF8, 64'hABCD_0000_0000_0003,
            64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_div("divuw_ff_1", F3_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
            64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_div("remuw_7_4", F3_REMU, 1'b1, 64'h0000_0001_0000_0007, 64'd4, 64'd3, 33);

    // A multiply encoding and a flushed request must both be ignored.
    dif.Funct3E = 3'b000;
    dif.MDUE    = 1'b1;
    #1;
    check("mul_busy", 64'(dif.DivBusyE), 64'd0);
    @(posedge clk); #1;
    check("mul_idle", 64'(dif.DivBusyE), 64'd0);
    dif.Funct3E = F3_DIVU;
    dif.FlushE  = 1'b1;
    #1;
    check("flush_idle_busy", 64'(dif.DivBusyE), 64'd0);
    @(posedge clk); #1;
    dif.MDUE   = 1'b0;
    dif.FlushE = 1'b0;
    #1;
    check("flush_idle_nostart", 64'(dif.DivBusyE), 64'd0);
    check("flush_idle_nodone", 64'(dif.DivDoneE), 64'd0);

    // Flush mid-divide, then restart in the following cycle.
    dif.Funct3E        = F3_DIVU;
    dif.W64E           = 1'b0;
    dif.ForwardedSrcAE = 64'd100;
    dif.ForwardedSrcBE = 64'd7;
    dif.MDUE           = 1'b1;
    @(posedge clk); #1;
    dif.MDUE = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("flush_busy_before", 64'(dif.DivBusyE), 64'd1);
    dif.FlushE = 1'b1;
    @(posedge clk); #1;
    dif.FlushE = 1'b0;
    check("flush_to_idle", 64'(dif.DivBusyE), 64'd0);
    check("flush_nodone", 64'(dif.DivDoneE), 64'd0);
    run_div("divu_9_3", F3_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 65);

    // Asynchronous reset in the middle of a divide.
    dif.Funct3E        = F3_DIVU;
    dif.ForwardedSrcAE = 64'd100;
    dif.ForwardedSrcBE = 64'd7;
    dif.MDUE           = 1'b1;
    @(posedge clk); #1;
    dif.MDUE = 1'b0;
    repeat (18) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(dif.DivBusyE), 64'd0);
    check("midrst_done", 64'(dif.DivDoneE), 64'd0);
    check("midrst_res", dif.DivResultE, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("postrst_nodone", 64'(dif.DivDoneE), 64'd0);
    end
    run_div("postrst_remu", F3_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
